// File: rtl/word_serializer_pkg.sv
// Shared state encoding and default parameter values for the word serializer.
package word_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam bit          DEF_MSB_FIRST  = 1'b1;
    localparam bit          DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/word_serializer_bit_counter.sv
// Bit position counter for the active word; saturates at WIDTH-1.
module word_serializer_bit_counter
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic Clock,
    input  logic Reset,
    input  logic clear,
    input  logic inc,
    output logic at_last
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !at_last) begin
            count <= count + CW'(1);
        end
    end

    assign at_last = (count == LAST);

endmodule

// File: rtl/word_serializer.sv
// Double-buffered parallel-to-serial converter: shift register plus one holding word.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter bit          MSB_FIRST  = DEF_MSB_FIRST,
    parameter bit          IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data,
    input  logic             Load,
    output logic             Ready,
    output logic             w,
    output logic             Busy,
    output logic             Last
);

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             cnt_clr, cnt_inc, at_last, accept;
    logic             w_q, w_n;

    word_serializer_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .Clock   (Clock),
        .Reset   (Reset),
        .clear   (cnt_clr),
        .inc     (cnt_inc),
        .at_last (at_last)
    );

    assign Busy   = (state == SHIFT);
    assign Last   = Busy && at_last;
    assign Ready  = Reset && (!hold_full || Last);
    assign accept = Load && Ready;
    assign w      = w_q;

    always_comb begin
        state_n     = state;
        sreg_n      = sreg;
        hold_n      = hold;
        hold_full_n = hold_full;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHIFT;
                    sreg_n  = Data;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (!at_last) begin
                    sreg_n  = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                    if (accept) begin
                        hold_n      = Data;
                        hold_full_n = 1'b1;
                    end
                end else begin
                    // Last bit: a held word takes priority; a same-edge load refills the hold.
                    cnt_clr = 1'b1;
                    if (hold_full) begin
                        sreg_n      = hold;
                        hold_full_n = accept;
                        if (accept) hold_n = Data;
                    end else if (accept) begin
                        sreg_n = Data;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        w_n = (state_n == SHIFT) ? (MSB_FIRST ? sreg_n[WIDTH-1] : sreg_n[0]) : IDLE_LEVEL;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            sreg      <= '0;
            hold      <= '0;
            hold_full <= 1'b0;
            w_q       <= IDLE_LEVEL;
        end else begin
            state     <= state_n;
            sreg      <= sreg_n;
            hold      <= hold_n;
            hold_full <= hold_full_n;
            w_q       <= w_n;
        end
    end

endmodule

// File: tb/tb_word_serializer.sv
// Scoreboard bench for word_serializer: MSB-first default instance plus an LSB-first instance.
module tb_word_serializer;

    localparam int W = 8;

    typedef struct {
        logic b;
        logic l;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data = '0, data2 = '0;
    logic         load = 1'b0, load2 = 1'b0;
    logic         ready, w, busy, last;
    logic         ready2, w2, busy2, last2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    sb_t q[$];
    sb_t q2[$];

    always #5 clk = ~clk;

    word_serializer dut (
        .Clock (clk), .Reset (rst_n), .Data (data), .Load (load),
        .Ready (ready), .w (w), .Busy (busy), .Last (last)
    );

    word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
        .Clock (clk), .Reset (rst_n), .Data (data2), .Load (load2),
        .Ready (ready2), .w (w2), .Busy (busy2), .Last (last2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic bit_of(input logic [W-1:0] d, input int i, input bit msb);
        logic [W-1:0] v;
        v = d;
        return msb ? v[W-1-i] : v[i];
    endfunction

    // Scoreboard for the MSB-first instance; hold is empty or on last bit iff <= W+1 bits pending.
    always @(negedge clk) begin
        sb_t  e;
        logic rdy_exp;
        if (!rst_n) begin
            q.delete();
            check("rst_w", w, 0);
            check("rst_busy", busy, 0);
            check("rst_ready", ready, 0);
        end else begin
            rdy_exp = (q.size() <= W + 1);
            check("ready", ready, rdy_exp);
            check("busy", busy, q.size() != 0);
            if (q.size() != 0) begin
                e = q.pop_front();
                check("w", w, e.b);
                check("last", last, e.l);
            end else begin
                check("w_idle", w, 0);
                check("last_idle", last, 0);
            end
            if (load && rdy_exp) begin
                for (int i = 0; i < W; i++) q.push_back('{b: bit_of(data, i, 1'b1), l: (i == W - 1)});
                n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        sb_t  e;
        logic rdy_exp;
        if (!rst_n) begin
            q2.delete();
        end else begin
            rdy_exp = (q2.size() <= W + 1);
            check("ready_lsb", ready2, rdy_exp);
            check("busy_lsb", busy2, q2.size() != 0);
            if (q2.size() != 0) begin
                e = q2.pop_front();
                check("w_lsb", w2, e.b);
                check("last_lsb", last2, e.l);
            end else begin
                check("w_idle_lsb", w2, 0);
            end
            if (load2 && rdy_exp) begin
                for (int i = 0; i < W; i++) q2.push_back('{b: bit_of(data2, i, 1'b0), l: (i == W - 1)});
            end
        end
    end

    task automatic pulse_load(input logic [W-1:0] d);
        load = 1'b1;
        data = d;
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    initial begin
        logic [W-1:0] words [3];
        int           base, seen;
        words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;

        repeat (2) @(posedge clk);
        #1;
        check("init_w", w, 0);
        check("init_busy", busy, 0);
        check("init_last", last, 0);
        check("init_ready", ready, 0);

        // Load immediately after reset release.
        rst_n = 1'b1;
        pulse_load(8'hD0);
        repeat (10) @(posedge clk);
        #1;

        // Back-to-back words, second one into the holding register.
        pulse_load(8'hAA);
        pulse_load(8'h55);
        repeat (18) @(posedge clk);
        #1;

        // Continuous Load, advancing only on accepted words.
        base = n_acc;
        for (int c = 0; c < 20; c++) begin
            if (n_acc - base < 3) begin
                load = 1'b1;
                data = words[n_acc - base];
            end else begin
                load = 1'b0;
            end
            @(posedge clk); #1;
        end
        load = 1'b0;
        check("three_words", n_acc - base, 3);
        repeat (12) @(posedge clk);
        #1;

        // Load during the Last cycle of the final held word.
        pulse_load(8'h3C);
        pulse_load(8'hC3);
        seen = 0;
        for (int c = 0; c < 40 && seen < 2; c++) begin
            @(posedge clk); #1;
            if (last) seen++;
        end
        check("last_seen", seen, 2);
        check("rdy_at_last", ready, 1);
        pulse_load(8'h96);
        repeat (10) @(posedge clk);
        #1;

        // LSB-first instance.
        load2 = 1'b1;
        data2 = 8'h0B;
        @(posedge clk); #1;
        load2 = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        // Asynchronous reset mid-word, then a fresh word.
        pulse_load(8'hFF);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_w", w, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 0);
        check("abort_last", last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_load(8'h80);
        repeat (12) @(posedge clk);
        #1;

        check("sb_empty", q.size(), 0);
        check("sb_empty_lsb", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of bits per parallel word (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1: 1 = shift out bit WIDTH-1 first; 0 = shift out bit 0 first.
REQ-003 Parameter IDLE_LEVEL, default 0: value driven on w when no word is being shifted.
REQ-004 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-006 Data  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
REQ-007 Load  input  1  load request; qualifies Data.
REQ-008 Ready  output  1  the block can accept a word this cycle.
REQ-009 w  output  1  serial bit stream for the sequence-detector stage; one bit per Clock.
REQ-010 Busy  output  1  a word bit is currently driven on w.
REQ-011 Last  output  1  the bit on w is the final bit of its word.

Function
REQ-012 A load SHALL be accepted on any rising edge where Load=1 and Ready=1; Load with Ready=0 SHALL be ignored, with no state change.
REQ-013 The datapath SHALL be double-buffered: one shift register (active word) plus one holding register (next word), each with a full flag.
REQ-014 FSM states SHALL be IDLE (shift register empty) and SHIFT (shift register holds an active word).
REQ-015 IDLE to SHIFT: on an accepted load, the word goes directly into the shift register and the bit counter is cleared to 0.
REQ-016 SHIFT: the shift register advances one bit per cycle, and the bit counter increments from 0 to WIDTH-1.
REQ-017 At counter=WIDTH-1 with the holding register full: the next edge moves the holding word into the shift register, clears the counter, clears the hold flag, and stays in SHIFT with no idle gap.
REQ-018 At counter=WIDTH-1 with the holding register empty: the next edge returns to IDLE, unless a load is accepted on that same edge, in which case the REQ-017 behaviour applies to the new word.
REQ-019 In SHIFT when not at the last bit, an accepted load SHALL fill the holding register.
REQ-020 Ready SHALL equal (Reset high) AND (hold empty OR (SHIFT AND Last)).
REQ-021 Latency: a word accepted on edge N SHALL drive its first bit on w from edge N (registered output, visible in cycle N+1) when the block is in IDLE or at the last bit.
REQ-022 w SHALL be registered and equal to the selected end of the shift register (MSB or LSB per MSB_FIRST) in SHIFT, and IDLE_LEVEL in IDLE.
REQ-023 Busy SHALL be 1 exactly while in SHIFT.
REQ-024 Last SHALL be 1 exactly when in SHIFT and counter=WIDTH-1.
REQ-025 Bit-counter width SHALL be clog2(WIDTH); the counter SHALL never exceed WIDTH-1 and SHALL never wrap silently.
REQ-026 No word SHALL ever be dropped or duplicated, and each word SHALL emit exactly WIDTH bits.

Reset
REQ-027 While Reset=0, the block SHALL be in IDLE with both full flags 0, counter 0, w=IDLE_LEVEL, Busy=0, Last=0, and Ready=0.
REQ-028 A Reset assertion mid-word SHALL abort the active and held words immediately, without waiting for Clock.
REQ-029 On the first edge after Reset deasserts, Ready=1 and a load is accepted normally.

Structure
REQ-030 A shared package SHALL hold the state encoding (IDLE, SHIFT) and the default WIDTH, MSB_FIRST and IDLE_LEVEL constants.
REQ-031 The block SHALL be a single module; no sub-module is required (an optional bit_counter helper is permitted).
REQ-032 The w output SHALL connect directly to the w input of the downstream sequence detector, with no glue logic.

Verification (WIDTH=8, MSB_FIRST=1, IDLE_LEVEL=0 unless stated)
REQ-033 Load 8'hD0 once from IDLE -> w = 1,1,0,1,0,0,0,0 over 8 consecutive cycles, Last on bit 8, Busy falls with w=0 afterwards; the downstream detector asserts z once.
REQ-034 Load 8'hAA, then 8'h55 while Ready=1 -> 16 contiguous bits 10101010 01010101, Busy stays 1 with no gap.
REQ-035 Hold Load=1 for 20 cycles with words 8'h01/8'h02/8'h03 advancing only on Ready=1 -> exactly three words emitted in order, none duplicated.
REQ-036 Assert Reset after 3 bits of 8'hFF -> w=0, Busy=0, Ready=0 immediately; after release, load 8'h80 -> 1,0,0,0,0,0,0,0.
REQ-037 With MSB_FIRST=0, load 8'h0B -> w = 1,1,0,1,0,0,0,0.
REQ-038 Load at the Last cycle of the final held word -> next word starts on the following cycle with no gap, and Ready=1 in that Last cycle.
